// File: rtl/mtm_alu_wide.sv
// Serial ALU with configurable operand width: receives B, A and a command frame on sin,
// answers with result + status frames (or a single error frame) on sout.
module mtm_alu_wide #(
    parameter int DATA_BYTES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    output logic sout
);

    localparam int W    = 8 * DATA_BYTES;
    localparam int SH_W = $clog2(W);
    // The count must be able to reach 2*DATA_BYTES (16 at the widest setting) without wrapping.
    localparam logic [4:0] CNT_MAX = (2 * DATA_BYTES >= 15) ? 5'd31 : 5'd15;
    localparam logic [4:0] CNT_EXP = 5'(2 * DATA_BYTES);
    localparam logic [3:0] LAST_FRM = 4'(DATA_BYTES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_FRAME,
        EXEC,
        TX
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       rx_bit_q, rx_bit_d;
    logic [8:0]       rx_sh_q, rx_sh_d;
    logic [2*W-1:0]   ops_q, ops_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       chk_q, chk_d;
    logic             stop_err_q, stop_err_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       chk_rx_q, chk_rx_d;
    logic [W-1:0]     res_q, res_d;
    logic [7:0]       stat_q, stat_d;
    logic             err_q, err_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [3:0]       tx_frm_q, tx_frm_d;
    logic             sout_q, sout_d;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= CNT_MAX) ? v : v + 5'd1;
    endfunction

    logic [W-1:0] op_a, op_b;
    assign op_b = ops_q[2*W-1:W];
    assign op_a = ops_q[W-1:0];

    // ALU and flag generation, evaluated from the registered request while in EXEC
    logic [W-1:0] alu_res;
    logic [W:0]   alu_ext;
    logic         alu_c, alu_v;

    always_comb begin
        alu_res = '0;
        alu_ext = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: alu_res = op_a & op_b;
            3'b001: alu_res = op_a | op_b;
            3'b010: alu_res = op_a ^ op_b;
            3'b011: alu_res = op_a << op_b[SH_W-1:0];
            3'b100: begin
                alu_ext = {1'b0, op_a} + {1'b0, op_b};
                alu_res = alu_ext[W-1:0];
                alu_c   = alu_ext[W];
                alu_v   = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
            end
            3'b101: begin
                alu_ext = {1'b0, op_a} - {1'b0, op_b};
                alu_res = alu_ext[W-1:0];
                alu_c   = alu_ext[W];
                alu_v   = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
            end
            default: ;
        endcase
    end

    logic       err_d_flag, err_c_flag, err_o_flag;
    logic       flg_z, flg_n;
    logic [6:0] err_pl;

    assign err_d_flag = (cnt_q != CNT_EXP) || stop_err_q;
    assign err_c_flag = !err_d_flag && ((chk_q ^ {1'b0, op_q}) != chk_rx_q);
    assign err_o_flag = !err_d_flag && op_q[2] && op_q[1];
    assign flg_z      = (alu_res == '0);
    assign flg_n      = alu_res[W-1];
    assign err_pl     = {1'b1, err_d_flag, err_c_flag, err_o_flag, err_d_flag, err_c_flag, err_o_flag};

    // Transmit bit selection: frames 0..DATA_BYTES-1 carry the result, the last one the status
    logic       tx_is_cmd, tx_val;
    logic [3:0] byte_idx;
    logic [7:0] tx_byte, tx_pay;
    logic [2:0] pidx;

    assign tx_is_cmd = err_q || (tx_frm_q == LAST_FRM);
    assign byte_idx  = 4'(DATA_BYTES - 1) - tx_frm_q;
    assign tx_byte   = 8'(res_q >> {byte_idx, 3'b000});
    assign tx_pay    = tx_is_cmd ? stat_q : tx_byte;
    assign pidx      = 3'(4'd9 - tx_bit_q);

    always_comb begin
        if (tx_bit_q == 4'd1)
            tx_val = tx_is_cmd;
        else if (tx_bit_q >= 4'd10)
            tx_val = 1'b1;
        else
            tx_val = tx_pay[pidx];
    end

    always_comb begin
        state_d    = state_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        ops_d      = ops_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        stop_err_d = stop_err_q;
        op_d       = op_q;
        chk_rx_d   = chk_rx_q;
        res_d      = res_q;
        stat_d     = stat_q;
        err_d      = err_q;
        tx_bit_d   = tx_bit_q;
        tx_frm_d   = tx_frm_q;
        sout_d     = sout_q;

        case (state_q)
            RX_IDLE: begin
                if (!sin) begin
                    state_d  = RX_FRAME;
                    rx_bit_d = 4'd0;
                end
            end
            RX_FRAME: begin
                rx_bit_d = rx_bit_q + 4'd1;
                if (rx_bit_q < 4'd9) begin
                    rx_sh_d = {rx_sh_q[7:0], sin};
                end else begin
                    rx_bit_d   = 4'd0;
                    stop_err_d = stop_err_q | !sin;
                    if (!rx_sh_q[8]) begin
                        ops_d   = {ops_q[2*W-9:0], rx_sh_q[7:0]};
                        cnt_d   = sat_inc(cnt_q);
                        chk_d   = chk_q ^ rx_sh_q[7:4] ^ rx_sh_q[3:0];
                        state_d = RX_IDLE;
                    end else begin
                        op_d     = rx_sh_q[6:4];
                        chk_rx_d = rx_sh_q[3:0];
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                res_d = alu_res;
                if (err_d_flag || err_c_flag || err_o_flag) begin
                    err_d  = 1'b1;
                    stat_d = {err_pl, ^err_pl};
                end else begin
                    err_d  = 1'b0;
                    stat_d = {1'b0, alu_c, alu_v, flg_z, flg_n, ^alu_res,
                              ^{alu_c, alu_v, flg_z, flg_n}, 1'b0};
                end
                cnt_d      = 5'd0;
                chk_d      = 4'd0;
                stop_err_d = 1'b0;
                sout_d     = 1'b0;
                tx_bit_d   = 4'd1;
                tx_frm_d   = 4'd0;
                state_d    = TX;
            end
            TX: begin
                if (tx_bit_q == 4'd11) begin
                    if (tx_frm_q == (err_q ? 4'd0 : LAST_FRM)) begin
                        sout_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        sout_d   = 1'b0;
                        tx_bit_d = 4'd1;
                        tx_frm_d = tx_frm_q + 4'd1;
                    end
                end else begin
                    sout_d   = tx_val;
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            ops_q      <= '0;
            cnt_q      <= '0;
            chk_q      <= '0;
            stop_err_q <= 1'b0;
            op_q       <= '0;
            chk_rx_q   <= '0;
            res_q      <= '0;
            stat_q     <= '0;
            err_q      <= 1'b0;
            tx_bit_q   <= '0;
            tx_frm_q   <= '0;
            sout_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            ops_q      <= ops_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            stop_err_q <= stop_err_d;
            op_q       <= op_d;
            chk_rx_q   <= chk_rx_d;
            res_q      <= res_d;
            stat_q     <= stat_d;
            err_q      <= err_d;
            tx_bit_q   <= tx_bit_d;
            tx_frm_q   <= tx_frm_d;
            sout_q     <= sout_d;
        end
    end

    assign sout = sout_q;

endmodule

// File: tb/tb_mtm_alu_wide.sv
// Directed bench for mtm_alu_wide: three instances (4, 1 and 8 bytes) driven by a serial BFM.
module tb_mtm_alu_wide;

    logic clk;
    logic rst_n;
    logic sin4, sin1, sin8;
    logic sout4, sout1, sout8;

    int n_cmp = 0;
    int n_mis = 0;

    mtm_alu_wide #(.DATA_BYTES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .sin(sin4), .sout(sout4));
    mtm_alu_wide #(.DATA_BYTES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .sin(sin1), .sout(sout1));
    mtm_alu_wide #(.DATA_BYTES(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .sin(sin8), .sout(sout8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_sout(input int sel);
        case (sel)
            1:       return sout1;
            8:       return sout8;
            default: return sout4;
        endcase
    endfunction

    task automatic set_sin(input int sel, input logic v);
        case (sel)
            1:       sin1 = v;
            8:       sin8 = v;
            default: sin4 = v;
        endcase
    endtask

    task automatic send_frame(input int sel, input logic typ, input logic [7:0] pay);
        @(negedge clk) set_sin(sel, 1'b0);
        @(negedge clk) set_sin(sel, typ);
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk) set_sin(sel, pay[b]);
        end
        @(negedge clk) set_sin(sel, 1'b1);
    endtask

    task automatic send_data(input int sel, input logic [63:0] val, input int nbytes);
        logic [63:0] v;
        v = val;
        for (int i = nbytes - 1; i >= 0; i--) begin
            send_frame(sel, 1'b0, v[8*i +: 8]);
        end
    endtask

    task automatic recv_frame(input int sel, input string tag,
                              output logic typ, output logic [7:0] pay, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        typ  = 1'b0;
        pay  = 8'h00;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (get_sout(sel) == 1'b0) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq({tag, ":start"}, 64'(seen), 64'd1);
        if (seen) begin
            @(negedge clk);
            typ = get_sout(sel);
            for (int b = 7; b >= 0; b--) begin
                @(negedge clk);
                pay[b] = get_sout(sel);
            end
            @(negedge clk);
            check_eq({tag, ":stop"}, 64'(get_sout(sel)), 64'd1);
        end
    endtask

    task automatic do_req(input int sel, input string tag, input int nb_dut,
                          input int nsend_b, input int nsend_a,
                          input logic [63:0] b, input logic [63:0] a, input logic [7:0] cmd,
                          input logic is_err, input logic [63:0] exp_res, input logic [7:0] exp_stat);
        logic        typ;
        logic [7:0]  pay;
        int          lat;
        logic        saw_low;
        logic [63:0] er;
        er = exp_res;
        send_data(sel, b, nsend_b);
        send_data(sel, a, nsend_a);
        send_frame(sel, 1'b1, cmd);
        if (!is_err) begin
            for (int f = 0; f < nb_dut; f++) begin
                recv_frame(sel, $sformatf("%s:d%0d", tag, f), typ, pay, lat);
                check_eq($sformatf("%s:d%0d_lat", tag, f), 64'(lat), (f == 0) ? 64'd2 : 64'd1);
                check_eq($sformatf("%s:d%0d_type", tag, f), 64'(typ), 64'd0);
                check_eq($sformatf("%s:d%0d_byte", tag, f), 64'(pay), 64'(er[8*(nb_dut-1-f) +: 8]));
            end
        end
        recv_frame(sel, {tag, ":st"}, typ, pay, lat);
        check_eq({tag, ":st_lat"}, 64'(lat), is_err ? 64'd2 : 64'd1);
        check_eq({tag, ":st_type"}, 64'(typ), 64'd1);
        check_eq({tag, ":st_pay"}, 64'(pay), 64'(exp_stat));
        saw_low = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (get_sout(sel) == 1'b0) saw_low = 1'b1;
        end
        check_eq({tag, ":quiet"}, 64'(saw_low), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        typ;
        logic [7:0]  pay;
        int          lat;

        rst_n = 1'b0;
        sin4  = 1'b1;
        sin1  = 1'b1;
        sin8  = 1'b1;
        #12;
        check_eq("rst_sout4", 64'(sout4), 64'd1);
        check_eq("rst_sout1", 64'(sout1), 64'd1);
        check_eq("rst_sout8", 64'(sout8), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_req(4, "add",   4, 4, 4, 64'h2,        64'h1,        8'h47, 1'b0, 64'h0000_0003, 8'h00);
        do_req(4, "sub",   4, 4, 4, 64'h1,        64'h0,        8'h54, 1'b0, 64'hFFFF_FFFF, 8'h48);
        do_req(4, "crc",   4, 4, 4, 64'h2,        64'h1,        8'h46, 1'b1, 64'h0,         8'hA5);
        do_req(4, "cnt",   4, 3, 0, 64'h000002,   64'h0,        8'h47, 1'b1, 64'h0,         8'hC9);
        do_req(4, "op110", 4, 4, 4, 64'h2,        64'h1,        8'h65, 1'b1, 64'h0,         8'h93);
        do_req(4, "ovf",   4, 4, 4, 64'h1,        64'h7FFF_FFFF, 8'h4D, 1'b0, 64'h8000_0000, 8'h2C);
        do_req(4, "sll",   4, 4, 4, 64'h1F,       64'h1,        8'h3C, 1'b0, 64'h8000_0000, 8'h0E);
        do_req(4, "xor",   4, 4, 4, 64'h0F0F_0F0F, 64'h00FF_00FF, 8'h22, 1'b0, 64'h0FF0_0FF0, 8'h00);
        do_req(4, "and",   4, 4, 4, 64'hF0F0_F0F0, 64'h0F0F_0F0F, 8'h00, 1'b0, 64'h0,         8'h12);

        // Reset while the third response frame (byte 0x00) is on the wire
        send_data(4, 64'h2, 4);
        send_data(4, 64'h1, 4);
        send_frame(4, 1'b1, 8'h47);
        recv_frame(4, "rst:f0", typ, pay, lat);
        recv_frame(4, "rst:f1", typ, pay, lat);
        repeat (3) @(negedge clk);
        check_eq("rst:pre_low", 64'(sout4), 64'd0);
        #2 rst_n = 1'b0;
        #1 check_eq("rst:sout_high", 64'(sout4), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("rst:held_high", 64'(sout4), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_req(4, "post_rst", 4, 4, 4, 64'h2, 64'h1, 8'h47, 1'b0, 64'h0000_0003, 8'h00);

        do_req(1, "w1_add", 1, 1, 1, 64'h01, 64'hFF,                  8'h45, 1'b0, 64'h0, 8'h50);
        do_req(8, "w8_add", 8, 8, 8, 64'h01, 64'hFFFF_FFFF_FFFF_FFFF, 8'h45, 1'b0, 64'h0, 8'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
